// File: rtl/mod_fetch.sv
// mod_fetch -- instruction-fetch stage sitting just after the PC register.
//
// Takes the current PC and issues word requests to instruction memory on a
// req/gnt/rvalid bus. The PC of every granted request is remembered in a
// pending-PC FIFO. Returned words are paired with their PC and queued in
// order for decode.
//
// Handshakes:
//   imem:   a request transfers when imem_req_o & imem_gnt_i. Responses come
//           back in order on imem_rvalid_i, at least one cycle after the grant.
//   decode: the head transfers when instr_valid_o & instr_ready_i. The head
//           stays stable while valid is high and ready is low.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   pc_i                     PC to fetch; stall_o=1 tells the PC register to hold
//   flush_i                  redirect: kills the queue and in-flight fetches
//   imem_req_o/addr_o        request valid / word-aligned address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    response valid / instruction word
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i   decode-side queue head
module mod_fetch #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  output logic            stall_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] pend_q [DEPTH];
  logic [XLEN-1:0] pend_d [DEPTH];
  ptr_t            pend_wp_q, pend_wp_d, pend_rp_q, pend_rp_d;

  logic [XLEN-1:0] qpc_q  [DEPTH];
  logic [XLEN-1:0] qpc_d  [DEPTH];
  logic [31:0]     qins_q [DEPTH];
  logic [31:0]     qins_d [DEPTH];
  ptr_t            q_wp_q, q_wp_d, q_rp_q, q_rp_d;

  cnt_t qcount_q, qcount_d;
  cnt_t outstanding_q, outstanding_d;
  cnt_t discard_q, discard_d;

  logic [CW:0] inflight;
  logic        credit_ok;
  logic        accept;
  logic        rsp_keep;
  logic        rsp_drop;
  logic        rv_dec;
  logic        q_push;
  logic        q_pop;

  // Credit rule: every outstanding request already owns a queue slot, so a
  // response can always be pushed and the queue never overflows.
  assign inflight   = {1'b0, outstanding_q} + {1'b0, qcount_q};
  assign credit_ok  = inflight < (CW+1)'(DEPTH);
  assign imem_req_o = rst_ni & ~flush_i & credit_ok;
  assign accept     = imem_req_o & imem_gnt_i;
  assign stall_o    = ~accept;
  assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};

  // A response that arrives during a flush is stale even when no discard is
  // pending yet, so the flush cycle never pushes.
  assign rsp_keep = imem_rvalid_i & ~flush_i & (discard_q == '0);
  assign rsp_drop = imem_rvalid_i & ~flush_i & (discard_q != '0);
  // Ignore a response that has no matching request, so the counter cannot wrap.
  assign rv_dec   = imem_rvalid_i & (outstanding_q != '0);
  assign q_push   = rsp_keep;
  assign q_pop    = instr_valid_o & instr_ready_i;

  assign instr_valid_o = (qcount_q != '0);
  assign instr_o       = qins_q[q_rp_q];
  assign instr_pc_o    = qpc_q[q_rp_q];

  always_comb begin
    pend_d        = pend_q;
    pend_wp_d     = pend_wp_q;
    pend_rp_d     = pend_rp_q;
    qpc_d         = qpc_q;
    qins_d        = qins_q;
    q_wp_d        = q_wp_q;
    q_rp_d        = q_rp_q;
    qcount_d      = qcount_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (flush_i) begin
      // Everything still in flight belongs to the old stream. The pending
      // PCs are dropped with the queue, and the discard counter swallows
      // their responses.
      pend_wp_d     = '0;
      pend_rp_d     = '0;
      q_wp_d        = '0;
      q_rp_d        = '0;
      qcount_d      = '0;
      outstanding_d = outstanding_q - cnt_t'(rv_dec);
      discard_d     = outstanding_q - cnt_t'(rv_dec);
    end else begin
      if (accept) begin
        pend_d[pend_wp_q] = pc_i;
        pend_wp_d         = pend_wp_q + ptr_t'(1);
      end
      if (rsp_keep) begin
        qpc_d[q_wp_q]  = pend_q[pend_rp_q];
        qins_d[q_wp_q] = imem_rdata_i;
        q_wp_d         = q_wp_q + ptr_t'(1);
        pend_rp_d      = pend_rp_q + ptr_t'(1);
      end
      if (rsp_drop) begin
        discard_d = discard_q - cnt_t'(1);
      end
      if (q_pop) begin
        q_rp_d = q_rp_q + ptr_t'(1);
      end
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(rv_dec);
      qcount_d      = qcount_q + cnt_t'(q_push) - cnt_t'(q_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend_q[i] <= '0;
        qpc_q[i]  <= '0;
        qins_q[i] <= '0;
      end
      pend_wp_q     <= '0;
      pend_rp_q     <= '0;
      q_wp_q        <= '0;
      q_rp_q        <= '0;
      qcount_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pend_q        <= pend_d;
      qpc_q         <= qpc_d;
      qins_q        <= qins_d;
      pend_wp_q     <= pend_wp_d;
      pend_rp_q     <= pend_rp_d;
      q_wp_q        <= q_wp_d;
      q_rp_q        <= q_rp_d;
      qcount_q      <= qcount_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_mod_fetch.sv
module tb_mod_fetch;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready;

  mod_fetch #(.XLEN(32), .DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pc_i          (pc),
    .stall_o       (stall),
    .flush_i       (flush),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (ready)
  );

  // ---------------- scoreboard state ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          deliveries = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mq[$];
  bit          mem_hold;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected stream: word at PC p is ~p in the memory model.
  task automatic load_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // ---------------- driver tasks ----------------
  // Call at a negedge. Handles one clock, then returns at the next negedge.
  task automatic tick();
    bit          acc;
    logic [31:0] a;
    logic [31:0] e;
    #1;
    acc = req & gnt;
    a   = addr;
    if (instr_valid && ready) begin
      deliveries++;
      if (exp_q.size() == 0) begin
        check("sb_extra", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e);
        check("sb_instr", instr, ~e);
      end
    end
    @(posedge clk);
    #1;
    if (acc) mq.push_back(a);
    if (!mem_hold && mq.size() != 0) begin
      rvalid = 1'b1;
      rdata  = ~mq.pop_front();
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    if (acc) pc = pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    mem_hold = 1'b0;
    mq.delete();
    rvalid = 1'b0;
    rdata  = 32'h0;
    pc = 32'h8000_0000;
    deliveries = 0;
    load_stream(32'h8000_0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (instr_valid) break;
      tick();
    end
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    gnt = 1'b1;
    ready = 1'b1;
    rst_n = 1'b0;
    flush = 1'b0;
    rvalid = 1'b0;
    rdata = 32'h0;
    pc = 32'h8000_0000;
    mem_hold = 1'b0;

    // ---- reset state (gnt high must not produce a request) ----
    @(negedge clk);
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ipc", instr_pc, 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);

    // ---- test 1: streaming, ready=1 ----
    apply_reset();
    #1;
    check("t1_req_c0", 32'(req), 32'd1);
    check("t1_stall_c0", 32'(stall), 32'd0);
    check("t1_addr_c0", addr, 32'h8000_0000);
    tick();
    check("t1_valid_c1", 32'(instr_valid), 32'd0);
    tick();
    check("t1_valid_c2", 32'(instr_valid), 32'd1);
    check("t1_ipc_c2", instr_pc, 32'h8000_0000);
    for (int i = 0; i < 15; i++) tick();
    check("t1_count", 32'(deliveries >= 8), 32'd1);

    // ---- test 2: decode stalled, queue fills, then drains in order ----
    ready = 1'b0;
    apply_reset();
    tick();
    tick();
    tick();
    check("t2_req_full", 32'(req), 32'd0);
    check("t2_stall_full", 32'(stall), 32'd1);
    check("t2_valid_full", 32'(instr_valid), 32'd1);
    check("t2_ipc_head", instr_pc, 32'h8000_0000);
    check("t2_addr_hold", addr, 32'h8000_0008);
    tick();
    check("t2_ipc_stable", instr_pc, 32'h8000_0000);
    check("t2_instr_stable", instr, 32'h7FFF_FFFF);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t2_count", 32'(deliveries >= 3), 32'd1);

    // ---- test 3: grant withheld for three cycles ----
    apply_reset();
    tick();
    tick();
    tick();
    gnt = 1'b0;
    #1;
    check("t3_stall_g0", 32'(stall), 32'd1);
    check("t3_req_g0", 32'(req), 32'd1);
    check("t3_addr_g0", addr, 32'h8000_0008);
    tick();
    check("t3_stall_g1", 32'(stall), 32'd1);
    check("t3_addr_g1", addr, 32'h8000_0008);
    tick();
    check("t3_stall_g2", 32'(stall), 32'd1);
    check("t3_addr_g2", addr, 32'h8000_0008);
    tick();
    gnt = 1'b1;
    #1;
    check("t3_stall_acc", 32'(stall), 32'd0);
    check("t3_addr_acc", addr, 32'h8000_0008);
    wait_valid("t3_wait", 12);
    check("t3_ipc", instr_pc, 32'h8000_0008);

    // ---- test 4: flush with two requests outstanding ----
    apply_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    check("t4_req_out2", 32'(req), 32'd0);
    flush = 1'b1;
    pc = 32'h8000_0100;
    load_stream(32'h8000_0100);
    #1;
    check("t4_req_flush", 32'(req), 32'd0);
    check("t4_stall_flush", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    mem_hold = 1'b0;
    check("t4_valid_c0", 32'(instr_valid), 32'd0);
    tick();
    check("t4_valid_c1", 32'(instr_valid), 32'd0);
    tick();
    check("t4_valid_c2", 32'(instr_valid), 32'd0);
    wait_valid("t4_wait", 12);
    check("t4_ipc", instr_pc, 32'h8000_0100);
    check("t4_instr", instr, 32'h7FFF_FEFF);

    // ---- test 5: flush in the same cycle as the only response ----
    apply_reset();
    tick();
    check("t5_rvalid", 32'(rvalid), 32'd1);
    flush = 1'b1;
    pc = 32'h8000_0200;
    load_stream(32'h8000_0200);
    tick();
    flush = 1'b0;
    #1;
    check("t5_req_after", 32'(req), 32'd1);
    check("t5_valid_after", 32'(instr_valid), 32'd0);
    wait_valid("t5_wait", 12);
    check("t5_ipc", instr_pc, 32'h8000_0200);

    // ---- test 6: asynchronous reset with the queue full ----
    ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) tick();
    check("t6_valid_pre", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid_async", 32'(instr_valid), 32'd0);
    check("t6_req_async", 32'(req), 32'd0);
    check("t6_stall_async", 32'(stall), 32'd1);
    check("t6_ipc_async", instr_pc, 32'd0);
    ready = 1'b1;
    apply_reset();
    wait_valid("t6_wait", 12);
    check("t6_ipc", instr_pc, 32'h8000_0000);
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
